// File: rtl/alpu_cache_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | alpu_cache_arbiter: round-robin two-requester sequencer for the ALPU cache   |
// | Rev 1.0 -- optional watchdog compiled in by ALPU_CACHE_ARB_WATCHDOG_EN       |
// +-----------------------------------------------------------------------------+
module alpu_cache_arbiter #(
  parameter int ADDR_WIDTH     = 4,
  parameter int DATA_WIDTH     = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req0_valid_i,
  input  logic                  req0_we_i,
  input  logic [ADDR_WIDTH-1:0] req0_addr_i,
  input  logic [DATA_WIDTH-1:0] req0_wdata_i,
  output logic                  req0_ready_o,
  input  logic                  req1_valid_i,
  input  logic                  req1_we_i,
  input  logic [ADDR_WIDTH-1:0] req1_addr_i,
  input  logic [DATA_WIDTH-1:0] req1_wdata_i,
  output logic                  req1_ready_o,
  output logic [DATA_WIDTH-1:0] resp0_rdata_o,
  output logic                  resp0_rvalid_o,
  output logic                  resp0_wack_o,
  output logic                  resp0_err_o,
  output logic [DATA_WIDTH-1:0] resp1_rdata_o,
  output logic                  resp1_rvalid_o,
  output logic                  resp1_wack_o,
  output logic                  resp1_err_o,
  output logic [ADDR_WIDTH-1:0] cache_addr_o,
  output logic [DATA_WIDTH-1:0] cache_wdata_o,
  output logic                  cache_ce_o,
  output logic                  cache_we_o,
  input  logic [DATA_WIDTH-1:0] cache_rdata_i,
  input  logic                  cache_rvalid_i,
  input  logic                  cache_wack_i
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]            state_q, state_d;
  logic                  owner_q, owner_d;
  logic                  last_grant_q, last_grant_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
  logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;
  logic                  rvalid_q, rvalid_d;
  logic                  wack_q, wack_d;
  logic                  err_q, err_d;

  logic                  grant0_w, grant1_w;
  logic                  done_w, timeout_w;
  logic [DATA_WIDTH-1:0] rsp_data_w;

  // On a tie the requester that was not granted last wins.
  assign grant0_w = (state_q == S_IDLE) && req0_valid_i && (!req1_valid_i || last_grant_q);
  assign grant1_w = (state_q == S_IDLE) && req1_valid_i && (!req0_valid_i || !last_grant_q);

  assign req0_ready_o = grant0_w && reset_n;
  assign req1_ready_o = grant1_w && reset_n;

  assign done_w     = we_q ? cache_wack_i : cache_rvalid_i;
  assign rsp_data_w = (done_w && !we_q) ? cache_rdata_i : '0;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    rvalid_d     = 1'b0;
    wack_d       = 1'b0;
    err_d        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (grant0_w || grant1_w) begin
          state_d      = S_BUSY;
          owner_d      = grant1_w;
          last_grant_d = grant1_w;
          we_d         = grant1_w ? req1_we_i    : req0_we_i;
          addr_d       = grant1_w ? req1_addr_i  : req0_addr_i;
          wdata_d      = grant1_w ? req1_wdata_i : req0_wdata_i;
        end
      end
      S_BUSY: begin
        // Completion has priority over a watchdog expiry in the same cycle.
        if (done_w || timeout_w) begin
          state_d  = S_RESP;
          rvalid_d = done_w && !we_q;
          wack_d   = done_w && we_q;
          err_d    = !done_w;
          if (owner_q) rdata1_d = rsp_data_w;
          else         rdata0_d = rsp_data_w;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
      rvalid_q     <= 1'b0;
      wack_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
      rvalid_q     <= rvalid_d;
      wack_q       <= wack_d;
      err_q        <= err_d;
    end
  end

`ifdef ALPU_CACHE_ARB_WATCHDOG_EN
  localparam int                 CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] wd_cnt_q, wd_cnt_d;

  // Counter is zero whenever BUSY is entered and counts BUSY cycles.
  assign wd_cnt_d  = (state_q == S_BUSY) ? wd_cnt_q + 1'b1 : '0;
  assign timeout_w = (state_q == S_BUSY) && (wd_cnt_q == LAST_CNT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) wd_cnt_q <= '0;
    else          wd_cnt_q <= wd_cnt_d;
  end

  assign resp0_err_o = err_q && !owner_q;
  assign resp1_err_o = err_q && owner_q;
`else
  logic unused_wd_w;

  assign timeout_w   = 1'b0;
  assign unused_wd_w = err_q ^ (TIMEOUT_CYCLES != 0);
  assign resp0_err_o = 1'b0;
  assign resp1_err_o = 1'b0;
`endif

  assign cache_ce_o     = (state_q == S_BUSY);
  assign cache_we_o     = (state_q == S_BUSY) && we_q;
  assign cache_addr_o   = addr_q;
  assign cache_wdata_o  = wdata_q;

  assign resp0_rvalid_o = rvalid_q && !owner_q;
  assign resp0_wack_o   = wack_q && !owner_q;
  assign resp1_rvalid_o = rvalid_q && owner_q;
  assign resp1_wack_o   = wack_q && owner_q;
  assign resp0_rdata_o  = rdata0_q;
  assign resp1_rdata_o  = rdata1_q;

endmodule
`default_nettype wire

// File: tb/tb_alpu_cache_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_alpu_cache_arbiter: directed + randomized bench with a transaction model  |
// | Rev 1.0                                                                      |
// +-----------------------------------------------------------------------------+
module tb_alpu_cache_arbiter;
  localparam int AW = 4;
  localparam int DW = 4;
  localparam int TO = 4;

  logic          clk      = 1'b0;
  logic          reset_n  = 1'b1;
  logic [1:0]    v        = '0;
  logic [1:0]    we       = '0;
  logic [AW-1:0] a  [2];
  logic [DW-1:0] wd [2];
  logic [DW-1:0] c_rdata  = '0;
  logic          c_rvalid = 1'b0;
  logic          c_wack   = 1'b0;
  logic [1:0]    rdy, rvld, wack, err;
  logic [DW-1:0] rd [2];
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_wdata;
  logic          c_ce, c_we;

  always #5 clk = ~clk;

  alpu_cache_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid_i(v[0]), .req0_we_i(we[0]), .req0_addr_i(a[0]), .req0_wdata_i(wd[0]),
    .req0_ready_o(rdy[0]),
    .req1_valid_i(v[1]), .req1_we_i(we[1]), .req1_addr_i(a[1]), .req1_wdata_i(wd[1]),
    .req1_ready_o(rdy[1]),
    .resp0_rdata_o(rd[0]), .resp0_rvalid_o(rvld[0]), .resp0_wack_o(wack[0]), .resp0_err_o(err[0]),
    .resp1_rdata_o(rd[1]), .resp1_rvalid_o(rvld[1]), .resp1_wack_o(wack[1]), .resp1_err_o(err[1]),
    .cache_addr_o(c_addr), .cache_wdata_o(c_wdata), .cache_ce_o(c_ce), .cache_we_o(c_we),
    .cache_rdata_i(c_rdata), .cache_rvalid_i(c_rvalid), .cache_wack_i(c_wack)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model: one in-flight transaction, then one pending response.
  bit            m_busy, m_resp, m_owner, m_lg, m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rd [2];
  int            m_wait, m_kind;
  bit            e_rdy [2];
  int            g_log [$];
  bit            auto_req   = 1'b0;
  bit            auto_cache = 1'b0;

  function automatic void m_clear();
    m_busy = 0; m_resp = 0; m_owner = 0; m_lg = 1; m_we = 0;
    m_addr = '0; m_wdata = '0; m_rd[0] = '0; m_rd[1] = '0;
    m_wait = 0; m_kind = 0;
  endfunction

  initial begin : compare
    bit any, win, idle;
    m_clear();
    forever begin
      @(negedge clk);
      if (!reset_n) m_clear();
      any  = v[0] | v[1];
      win  = (v[0] && v[1]) ? !m_lg : v[1];
      idle = !m_busy && !m_resp;
      for (int n = 0; n < 2; n++) e_rdy[n] = reset_n && idle && any && (int'(win) == n);
      chk("ready0", rdy[0], e_rdy[0]);
      chk("ready1", rdy[1], e_rdy[1]);
      chk("cache_ce", c_ce, m_busy);
      chk("cache_we", c_we, m_busy && m_we);
      chk("cache_addr", c_addr, m_addr);
      chk("cache_wdata", c_wdata, m_wdata);
      for (int n = 0; n < 2; n++) begin
        chk($sformatf("resp%0d_rvalid", n), rvld[n], m_resp && m_owner == n && m_kind == 0);
        chk($sformatf("resp%0d_wack", n),   wack[n], m_resp && m_owner == n && m_kind == 1);
        chk($sformatf("resp%0d_err", n),    err[n],  m_resp && m_owner == n && m_kind == 2);
        chk($sformatf("resp%0d_rdata", n),  rd[n],   m_rd[n]);
      end
      if (reset_n) begin
        if (m_resp) m_resp = 0;
        else if (m_busy) begin
          m_wait++;
          if (m_we ? c_wack : c_rvalid) begin
            m_busy = 0; m_resp = 1; m_kind = m_we ? 1 : 0;
            m_rd[m_owner] = m_we ? '0 : c_rdata;
          end else begin
`ifdef ALPU_CACHE_ARB_WATCHDOG_EN
            if (m_wait == TO) begin
              m_busy = 0; m_resp = 1; m_kind = 2; m_rd[m_owner] = '0;
            end
`endif
          end
        end else if (any) begin
          m_busy = 1; m_wait = 0; m_owner = win; m_lg = win;
          m_we = we[win]; m_addr = a[win]; m_wdata = wd[win];
          g_log.push_back(int'(win));
        end
      end
    end
  end

  task automatic new_payload(input int n);
    we[n] = 1'($urandom);
    a[n]  = AW'($urandom);
    wd[n] = DW'($urandom);
  endtask

  // Advance to just after the next rising edge, then apply any random stimulus.
  task automatic tick();
    bit was;
    @(posedge clk);
    #1;
    if (auto_cache) begin
      c_rvalid = ($urandom_range(0, 3) == 0);
      c_wack   = ($urandom_range(0, 3) == 0);
      c_rdata  = DW'($urandom);
    end
    if (auto_req) begin
      for (int n = 0; n < 2; n++) begin
        was = v[n];
        if (v[n] && e_rdy[n]) v[n] = 1'b0;
        else if (v[n] && $urandom_range(0, 19) == 0) v[n] = 1'b0;
        if (!was && $urandom_range(0, 2) == 0) begin
          new_payload(n);
          v[n] = 1'b1;
        end
      end
    end
  endtask

  task automatic wait_acc(input int n);
    bit got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      tick();
      got = e_rdy[n];
    end
    v[n] = 1'b0;
    chk($sformatf("accept%0d", n), got, 1);
  endtask

  task automatic drain();
    bit ok = 0;
    v = 2'b00; auto_req = 0; auto_cache = 1;
    for (int i = 0; i < 100 && !ok; i++) begin
      tick();
      ok = !m_busy && !m_resp;
    end
    auto_cache = 0; c_rvalid = 0; c_wack = 0;
    chk("drain_idle", ok, 1);
  endtask

  initial begin : stim
    int n_ce;
    a[0] = '0; a[1] = '0; wd[0] = '0; wd[1] = '0;
    #2 reset_n = 1'b0;
    v = 2'b11; we = 2'b00; a[0] = 4'h1; a[1] = 4'h2;
    #5;
    chk("rst_ce", c_ce, 0);
    chk("rst_ready", rdy, 0);
    chk("rst_rdata0", rd[0], 0);
    chk("rst_addr", c_addr, 0);
    repeat (3) tick();
    reset_n = 1'b1;

    // Contention: both requesters valid from reset, payload refreshed on each accept.
    auto_cache = 1;
    for (int i = 0; i < 300 && g_log.size() < 6; i++) begin
      tick();
      for (int n = 0; n < 2; n++) if (e_rdy[n]) new_payload(n);
    end
    chk("contention_count", g_log.size(), 6);
    for (int i = 0; i < 6 && i < g_log.size(); i++) chk($sformatf("tie_grant%0d", i), g_log[i], i % 2);

    // Single read, data returned in the second BUSY cycle.
    drain();
    we[0] = 1'b0; a[0] = 4'h3; v[0] = 1'b1;
    wait_acc(0);
    chk("rd_ce_c1", c_ce, 1);
    chk("rd_addr", c_addr, 4'h3);
    tick();
    c_rvalid = 1'b1; c_rdata = 4'hA;
    chk("rd_ce_c2", c_ce, 1);
    tick();
    c_rvalid = 1'b0;
    chk("rd_ce_off", c_ce, 0);
    chk("rd_rvalid", rvld[0], 1);
    chk("rd_rdata", rd[0], 4'hA);
    chk("rd_resp1_quiet", rvld[1], 0);
    chk("model_rd0", m_rd[0], 4'hA);
    tick();
    chk("rd_pulse_len", rvld[0], 0);
    chk("rd_hold", rd[0], 4'hA);

    // Single write from req1, with a stray rvalid that must be ignored.
    drain();
    we[1] = 1'b1; a[1] = 4'h5; wd[1] = 4'h9; v[1] = 1'b1;
    wait_acc(1);
    c_rvalid = 1'b1; c_rdata = 4'h7;
    chk("wr_ce", c_ce, 1);
    chk("wr_we", c_we, 1);
    chk("wr_addr", c_addr, 4'h5);
    chk("wr_wdata", c_wdata, 4'h9);
    tick();
    c_rvalid = 1'b0; c_wack = 1'b1;
    chk("wr_hold_ce", c_ce, 1);
    chk("wr_hold_wdata", c_wdata, 4'h9);
    tick();
    c_wack = 1'b0;
    chk("wr_wack", wack[1], 1);
    chk("wr_rdata1", rd[1], 0);
    chk("wr_resp0_quiet", {rvld[0], wack[0], err[0]}, 0);
    chk("wr_ce_off", c_ce, 0);

    // Read that sees a wrong-type completion first.
    drain();
    we[0] = 1'b0; a[0] = 4'h7; v[0] = 1'b1;
    wait_acc(0);
    c_wack = 1'b1;
    tick();
    c_wack = 1'b0;
    chk("wrong_ce", c_ce, 1);
    chk("wrong_no_resp", rvld[0], 0);
    c_rvalid = 1'b1; c_rdata = 4'h5;
    tick();
    c_rvalid = 1'b0;
    chk("wrong_rvalid", rvld[0], 1);
    chk("wrong_rdata", rd[0], 4'h5);

    // Cache never answers.
    drain();
    we[1] = 1'b0; a[1] = 4'h2; v[1] = 1'b1;
    wait_acc(1);
    n_ce = 0;
    for (int i = 0; i < 20 && c_ce; i++) begin
      n_ce++;
      tick();
    end
`ifdef ALPU_CACHE_ARB_WATCHDOG_EN
    chk("wd_ce_cycles", n_ce, TO);
    chk("wd_err", err[1], 1);
    chk("wd_rdata", rd[1], 0);
    chk("wd_no_rvalid", rvld[1], 0);
    tick();
    chk("wd_idle", err[1], 0);
`else
    chk("hang_ce_cycles", n_ce, 20);
    chk("hang_err", err[1], 0);
    c_rvalid = 1'b1; c_rdata = 4'hE;
    tick();
    c_rvalid = 1'b0;
    chk("hang_release", rvld[1], 1);
`endif

    // Asynchronous reset in the middle of a write.
    drain();
    we[0] = 1'b1; a[0] = 4'h6; wd[0] = 4'h3; v[0] = 1'b1;
    wait_acc(0);
    chk("pre_rst_ce", c_ce, 1);
    #2 reset_n = 1'b0;
    c_wack = 1'b1;
    #1;
    chk("arst_ce", c_ce, 0);
    chk("arst_we", c_we, 0);
    chk("arst_addr", c_addr, 0);
    chk("arst_resp", {rvld, wack, err}, 0);
    chk("arst_rdata0", rd[0], 0);
    tick();
    tick();
    reset_n = 1'b1; c_wack = 1'b0;
    tick();
    tick();
    chk("post_rst_quiet", {rvld, wack, err}, 0);
    a[0] = 4'hC; a[1] = 4'hD; we = 2'b00; v = 2'b11;
    wait_acc(0);
    v = 2'b00;
    chk("post_rst_tie", c_addr, 4'hC);

    // Randomized traffic.
    auto_cache = 1; auto_req = 1;
    repeat (1500) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
